// File: rtl/icache_refill_pkg.sv
// Shared definitions for the instruction-cache refill engine and the fetch stage.
//   state_e    : refill FSM states
//   LINE_BYTES : bytes per cache line (one 64-bit beat)
//   IDX_LSB/IDX_MSB/TAG_LSB : PC bit positions of the line index and the tag
//   burst_base : byte address of the aligned burst that contains an address
package icache_refill_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRecv,
    StCommit,
    StSettle
  } state_e;

  localparam int unsigned LINE_BYTES = 8;
  localparam int unsigned IDX_LSB    = 3;
  localparam int unsigned IDX_MSB    = 7;
  localparam int unsigned TAG_LSB    = 8;

  // A burst covers beats*LINE_BYTES bytes and is naturally aligned to that size.
  function automatic logic [31:0] burst_base(input logic [31:0] addr,
                                             input int unsigned beats);
    return addr & ~32'(beats * LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/icache_refill_beat_counter.sv
// Beat counter for a refill burst.
//   clk, reset : clock and synchronous active-high reset
//   load       : capture base line index and restart the count at zero
//   inc        : one beat accepted, advance the count
//   base       : aligned first line index of the burst
//   fill_idx   : line index for the beat currently being accepted (base + count)
//   last       : the beat being accepted is the final one of the burst
module refill_beat_counter #(
  parameter int unsigned BEATS = 4,
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic [IDX_W-1:0] base,
  output logic [IDX_W-1:0] fill_idx,
  output logic             last
);

  logic [IDX_W-1:0] base_q, base_d;
  logic [IDX_W-1:0] count_q, count_d;

  always_comb begin
    base_d  = base_q;
    count_d = count_q;
    if (load) begin
      base_d  = base;
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q  <= '0;
      count_q <= '0;
    end else begin
      base_q  <= base_d;
      count_q <= count_d;
    end
  end

  // Base is aligned to BEATS lines, so the sum never leaves the group; the
  // add still wraps modulo 2^IDX_W by construction.
  assign fill_idx = base_q + count_q;
  assign last     = (count_q == IDX_W'(BEATS - 1));

endmodule

// File: rtl/icache_refill.sv
// Instruction-cache miss handler: freezes fetch, bursts a line group from
// memory, streams each beat into the cache data array, then writes the tag.
//   clk, reset          : clock, synchronous active-high reset
//   miss, pc            : fetch-stage tag miss and current fetch PC
//   stall               : holds the fetch PC while a miss is pending or serviced
//   mem_req, mem_addr   : burst read request and aligned base byte address
//   mem_ack             : memory accepted the request
//   mem_valid, mem_data : returned read beats
//   fill, fill_idx, stream : cache line write strobe, index and data
//   tag_write, tag_idx, tag_value : tag store write
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int unsigned BEATS = 4,
  parameter int unsigned IDX_W = 5,
  parameter int unsigned TAG_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             miss,
  input  logic [31:0]      pc,
  output logic             stall,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic             mem_valid,
  input  logic [63:0]      mem_data,
  output logic             fill,
  output logic [IDX_W-1:0] fill_idx,
  output logic [63:0]      stream,
  output logic             tag_write,
  output logic [IDX_W-1:0] tag_idx,
  output logic [TAG_W-1:0] tag_value
);

  state_e state_q, state_d;

  logic [31:0]      miss_pc_q, miss_pc_d;
  logic             fill_q, fill_d;
  logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
  logic [63:0]      stream_q, stream_d;

  logic             beat_accept;
  logic             cnt_load;
  logic             cnt_last;
  logic [IDX_W-1:0] cnt_base;
  logic [IDX_W-1:0] cnt_fill_idx;

  assign beat_accept = (state_q == StRecv) && mem_valid;
  assign cnt_load    = (state_q == StIdle) && miss;
  // First line of the aligned BEATS-line group holding the missing line.
  assign cnt_base    = IDX_W'(pc[IDX_MSB:IDX_LSB]) & ~IDX_W'(BEATS - 1);

  refill_beat_counter #(
    .BEATS(BEATS),
    .IDX_W(IDX_W)
  ) u_beat_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .inc     (beat_accept),
    .base    (cnt_base),
    .fill_idx(cnt_fill_idx),
    .last    (cnt_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (miss) state_d = StReq;
      StReq:    if (mem_ack) state_d = StRecv;
      StRecv:   if (beat_accept && cnt_last) state_d = StCommit;
      StCommit: state_d = StSettle;
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; stall also follows miss so fetch freezes in
  // the very cycle the miss is seen.
  always_comb begin
    stall     = miss || (state_q != StIdle);
    mem_req   = (state_q == StReq);
    tag_write = (state_q == StCommit);
  end

  // Datapath: latched miss PC and the registered fill port. Beats are
  // presented to the cache one cycle after memory returns them.
  always_comb begin
    miss_pc_d  = miss_pc_q;
    fill_d     = beat_accept;
    fill_idx_d = fill_idx_q;
    stream_d   = stream_q;
    if (cnt_load) begin
      miss_pc_d = pc;
    end
    if (beat_accept) begin
      fill_idx_d = cnt_fill_idx;
      stream_d   = mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      miss_pc_q  <= '0;
      fill_q     <= 1'b0;
      fill_idx_q <= '0;
      stream_q   <= '0;
    end else begin
      miss_pc_q  <= miss_pc_d;
      fill_q     <= fill_d;
      fill_idx_q <= fill_idx_d;
      stream_q   <= stream_d;
    end
  end

  // miss_pc only changes in idle, so the request address is stable until ack.
  assign mem_addr  = burst_base(miss_pc_q, BEATS);
  assign fill      = fill_q;
  assign fill_idx  = fill_idx_q;
  assign stream    = stream_q;
  assign tag_idx   = IDX_W'(miss_pc_q[IDX_MSB:IDX_LSB]);
  assign tag_value = TAG_W'(miss_pc_q[31:TAG_LSB]);

endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: a BEATS=4 instance driven by a table of refills, a
// randomized refill loop checked against an arithmetic model, and hand
// sequences for reset mid-burst, back-to-back misses and a BEATS=1 instance.
`timescale 1ns/1ps
module tb_icache_refill;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        miss, mem_ack, mem_valid;
  logic [31:0] pc;
  logic [63:0] mem_data;
  logic        stall, mem_req, fill, tag_write;
  logic [31:0] mem_addr;
  logic [4:0]  fill_idx, tag_idx;
  logic [63:0] stream;
  logic [23:0] tag_value;

  logic        miss1, mem_ack1, mem_valid1;
  logic [31:0] pc1;
  logic [63:0] mem_data1;
  logic        stall1, mem_req1, fill1, tag_write1;
  logic [31:0] mem_addr1;
  logic [4:0]  fill_idx1, tag_idx1;
  logic [63:0] stream1;
  logic [23:0] tag_value1;

  icache_refill #(.BEATS(4), .IDX_W(5), .TAG_W(24)) dut (
    .clk(clk), .reset(reset), .miss(miss), .pc(pc), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_valid(mem_valid), .mem_data(mem_data), .fill(fill), .fill_idx(fill_idx),
    .stream(stream), .tag_write(tag_write), .tag_idx(tag_idx), .tag_value(tag_value)
  );

  icache_refill #(.BEATS(1), .IDX_W(5), .TAG_W(24)) dut1 (
    .clk(clk), .reset(reset), .miss(miss1), .pc(pc1), .stall(stall1),
    .mem_req(mem_req1), .mem_addr(mem_addr1), .mem_ack(mem_ack1),
    .mem_valid(mem_valid1), .mem_data(mem_data1), .fill(fill1), .fill_idx(fill_idx1),
    .stream(stream1), .tag_write(tag_write1), .tag_idx(tag_idx1), .tag_value(tag_value1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Outputs sampled at the falling edge of the cycle just completed.
  logic        s_stall, s_req, s_fill, s_tw;
  logic [31:0] s_addr;
  logic [4:0]  s_idx, s_tidx;
  logic [63:0] s_stream;
  logic [23:0] s_tval;
  logic        t_stall, t_req, t_fill, t_tw;
  logic [31:0] t_addr;
  logic [4:0]  t_idx, t_tidx;
  logic [63:0] t_stream;
  logic [23:0] t_tval;

  task automatic cyc();
    @(negedge clk);
    s_stall = stall;  s_req = mem_req;   s_fill = fill;     s_tw = tag_write;
    s_addr = mem_addr; s_idx = fill_idx; s_stream = stream; s_tidx = tag_idx;
    s_tval = tag_value;
    t_stall = stall1;   t_req = mem_req1;   t_fill = fill1;     t_tw = tag_write1;
    t_addr = mem_addr1; t_idx = fill_idx1; t_stream = stream1; t_tidx = tag_idx1;
    t_tval = tag_value1;
    @(posedge clk);
    #1;
  endtask

  // Reference model for a 4-beat burst, from address arithmetic alone.
  function automatic logic [31:0] m_addr(input logic [31:0] p);
    return (p / 32) * 32;
  endfunction
  function automatic logic [4:0] m_line(input logic [31:0] p);
    return 5'((p / 8) % 32);
  endfunction
  function automatic logic [4:0] m_base(input logic [31:0] p);
    return 5'((((p / 8) % 32) / 4) * 4);
  endfunction
  function automatic logic [23:0] m_tag(input logic [31:0] p);
    return 24'(p / 256);
  endfunction

  // One complete refill on the BEATS=4 instance, checked cycle by cycle.
  task automatic refill(input logic [31:0] pc_v, input int ack_dly,
                        input int g0, input int g1, input int g2, input int g3,
                        input bit hold, input logic [31:0] e_addr,
                        input logic [4:0] e_base, input logic [4:0] e_tidx,
                        input logic [23:0] e_tag, input string nm);
    int gaps[4];
    int stall_cyc, fills, tws, gap_sum;
    logic pend;
    logic [4:0]  pend_idx;
    logic [63:0] pend_data;
    gaps = '{g0, g1, g2, g3};
    gap_sum = g0 + g1 + g2 + g3;
    miss = 1'b1; pc = pc_v; mem_ack = 1'b0; mem_valid = 1'b0;
    cyc();
    chk({nm, " stall_on_miss"}, 64'(s_stall), 64'd1);
    chk({nm, " idle_quiet"}, 64'({s_req, s_fill, s_tw}), 64'd0);
    stall_cyc = 1; fills = 0; tws = 0;
    if (!hold) miss = 1'b0;
    pc = $urandom();
    for (int i = 0; i <= ack_dly; i++) begin
      mem_ack   = (i == ack_dly);
      mem_valid = 1'($urandom_range(0, 1));
      mem_data  = {$urandom(), $urandom()};
      cyc();
      stall_cyc += int'(s_stall);
      chk({nm, " req_held"}, 64'(s_req), 64'd1);
      chk({nm, " req_addr"}, 64'(s_addr), 64'(e_addr));
      chk({nm, " no_fill_before_ack"}, 64'({s_fill, s_tw}), 64'd0);
    end
    mem_ack = 1'b0;
    pend = 1'b0; pend_idx = '0; pend_data = '0;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g <= gaps[b]; g++) begin
        mem_valid = (g == gaps[b]);
        mem_data  = {$urandom(), $urandom()};
        cyc();
        stall_cyc += int'(s_stall);
        fills += int'(s_fill);
        tws += int'(s_tw);
        chk({nm, " recv_fill"}, 64'(s_fill), 64'(pend));
        chk({nm, " recv_no_tag"}, 64'(s_tw), 64'd0);
        if (pend) begin
          chk({nm, " fill_idx"}, 64'(s_idx), 64'(pend_idx));
          chk({nm, " stream"}, s_stream, pend_data);
        end
        pend = mem_valid; pend_idx = e_base + 5'(b); pend_data = mem_data;
      end
    end
    mem_valid = 1'($urandom_range(0, 1));
    mem_data  = {$urandom(), $urandom()};
    cyc();
    stall_cyc += int'(s_stall);
    fills += int'(s_fill);
    tws += int'(s_tw);
    chk({nm, " commit_fill"}, 64'(s_fill), 64'd1);
    chk({nm, " commit_fill_idx"}, 64'(s_idx), 64'(pend_idx));
    chk({nm, " commit_stream"}, s_stream, pend_data);
    chk({nm, " tag_write"}, 64'(s_tw), 64'd1);
    chk({nm, " tag_idx"}, 64'(s_tidx), 64'(e_tidx));
    chk({nm, " tag_value"}, 64'(s_tval), 64'(e_tag));
    mem_valid = 1'($urandom_range(0, 1));
    cyc();
    stall_cyc += int'(s_stall);
    chk({nm, " settle_quiet"}, 64'({s_req, s_fill, s_tw}), 64'd0);
    chk({nm, " fill_count"}, 64'(fills), 64'd4);
    chk({nm, " tag_count"}, 64'(tws), 64'd1);
    chk({nm, " stall_cycles"}, 64'(stall_cyc), 64'(8 + ack_dly + gap_sum));
    mem_valid = 1'b0;
    if (!hold) begin
      cyc();
      chk({nm, " released"}, 64'({s_stall, s_req, s_fill, s_tw}), 64'd0);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    int          ack_dly;
    logic [31:0] addr;
    logic [4:0]  base;
    logic [4:0]  tidx;
    logic [23:0] tag;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] rp;
    vecs[0] = '{32'h0000_0134, 0, 32'h0000_0120, 5'd4,  5'd6,  24'h000001};
    vecs[1] = '{32'hDEAD_BEEF, 1, 32'hDEAD_BEE0, 5'd28, 5'd29, 24'hDEADBE};
    vecs[2] = '{32'h0000_0000, 5, 32'h0000_0000, 5'd0,  5'd0,  24'h000000};
    vecs[3] = '{32'h1234_56F8, 2, 32'h1234_56E0, 5'd28, 5'd31, 24'h123456};
    vecs[4] = '{32'h8000_0048, 0, 32'h8000_0040, 5'd8,  5'd9,  24'h800000};

    reset = 1'b1;
    miss = 1'b0; pc = '0; mem_ack = 1'b0; mem_valid = 1'b0; mem_data = '0;
    miss1 = 1'b0; pc1 = '0; mem_ack1 = 1'b0; mem_valid1 = 1'b0; mem_data1 = '0;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk("reset strobes", 64'({s_stall, s_req, s_fill, s_tw}), 64'd0);
    chk("reset mem_addr", 64'(s_addr), 64'd0);
    chk("reset fill_idx", 64'(s_idx), 64'd0);
    chk("reset stream", s_stream, 64'd0);
    chk("reset tag_idx", 64'(s_tidx), 64'd0);
    chk("reset tag_value", 64'(s_tval), 64'd0);
    chk("reset1 strobes", 64'({t_stall, t_req, t_fill, t_tw}), 64'd0);

    // Reset in the middle of a burst, with beats still arriving.
    miss = 1'b1; pc = 32'h0000_0134;
    cyc();
    miss = 1'b0; mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0; mem_valid = 1'b1; mem_data = 64'h1111;
    cyc();
    mem_data = 64'h2222;
    cyc();
    reset = 1'b1; mem_data = 64'h3333;
    cyc();
    reset = 1'b0; mem_data = 64'h4444;
    cyc();
    chk("midreset idle", 64'({s_stall, s_req, s_fill, s_tw}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1; mem_data = {$urandom(), $urandom()};
      cyc();
      chk("midreset stray_valid", 64'({s_stall, s_fill, s_tw}), 64'd0);
    end
    mem_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      refill(vecs[i].pc, vecs[i].ack_dly, 0, 0, 0, 0, 1'b0, vecs[i].addr,
             vecs[i].base, vecs[i].tidx, vecs[i].tag, $sformatf("vec%0d", i));
    end

    // Valid pattern 1,0,0,1,1,0,1.
    refill(32'h0000_0134, 0, 0, 2, 0, 1, 1'b0, 32'h0000_0120, 5'd4, 5'd6,
           24'h000001, "gaps");

    // Miss still high after SETTLE: a second full refill must follow.
    refill(32'h0000_0A58, 0, 0, 0, 0, 0, 1'b1, m_addr(32'h0000_0A58),
           m_base(32'h0000_0A58), m_line(32'h0000_0A58), m_tag(32'h0000_0A58), "held1");
    refill(32'h0000_0A58, 1, 1, 0, 1, 0, 1'b0, m_addr(32'h0000_0A58),
           m_base(32'h0000_0A58), m_line(32'h0000_0A58), m_tag(32'h0000_0A58), "held2");

    for (int i = 0; i < 20; i++) begin
      rp = $urandom();
      refill(rp, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)), 1'b0, m_addr(rp), m_base(rp), m_line(rp),
             m_tag(rp), $sformatf("rand%0d", i));
    end

    // Single-beat bursts at the top of the address space.
    miss1 = 1'b1; pc1 = 32'hFFFF_FFF8;
    cyc();
    chk("b1 stall_on_miss", 64'(t_stall), 64'd1);
    miss1 = 1'b0; mem_ack1 = 1'b1;
    cyc();
    chk("b1 req", 64'(t_req), 64'd1);
    chk("b1 mem_addr", 64'(t_addr), 64'hFFFF_FFF8);
    mem_ack1 = 1'b0; mem_valid1 = 1'b1; mem_data1 = 64'h0123_4567_89AB_CDEF;
    cyc();
    chk("b1 recv_quiet", 64'({t_fill, t_tw}), 64'd0);
    mem_valid1 = 1'b1; mem_data1 = 64'hFFFF_0000_FFFF_0000;
    cyc();
    chk("b1 fill", 64'(t_fill), 64'd1);
    chk("b1 fill_idx", 64'(t_idx), 64'd31);
    chk("b1 stream", t_stream, 64'h0123_4567_89AB_CDEF);
    chk("b1 tag_write", 64'(t_tw), 64'd1);
    chk("b1 tag_idx", 64'(t_tidx), 64'd31);
    chk("b1 tag_value", 64'(t_tval), 64'hFF_FFFF);
    mem_valid1 = 1'b0;
    cyc();
    chk("b1 settle", 64'({t_stall, t_fill, t_tw}), 64'b100);
    cyc();
    chk("b1 released", 64'({t_stall, t_req, t_fill, t_tw}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Miss-handling engine directly upstream of the fetch stage's instruction cache.
- On a fetch miss it freezes the PC and issues a burst read to memory.
- It streams each returned 64-bit line into the cache through the fill/fill_idx/stream interface, then writes the tag and releases fetch.
- It sits between the fetch stage and the memory/bus arbiter.

Parameters:
BEATS, 4, 64-bit lines per refill burst; power of two, 1..32
IDX_W, 5, cache line index width
TAG_W, 24, tag width written to the tag store

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
miss  in  1  fetch-stage tag miss for current PC
pc  in  32  current fetch PC
stall  out  1  forces fetch pc_write low while high
mem_req  out  1  burst read request
mem_addr  out  32  burst base byte address
mem_ack  in  1  memory accepted request
mem_valid  in  1  read beat valid
mem_data  in  64  read beat data
fill  out  1  cache line write strobe
fill_idx  out  IDX_W  cache line index being written
stream  out  64  cache line data
tag_write  out  1  tag store write strobe
tag_idx  out  IDX_W  tag store index
tag_value  out  TAG_W  tag to write

Behaviour:
- Reset: synchronous, active-high.
  - state=IDLE, beat counter=0.
  - stall, mem_req, fill and tag_write are all 0.
  - mem_addr, fill_idx, stream, tag_idx and tag_value are all 0.
  - Reset wins over every other input, including in the middle of a refill; any in-flight beats are then ignored.
- States: IDLE, REQ, RECV, COMMIT, SETTLE.
- stall = miss | (state != IDLE), combinational, so fetch is frozen in the same cycle the miss appears.
- IDLE:
  - If miss=1, latch pc into miss_pc.
  - base_idx = pc[7:3] with its low log2(BEATS) bits cleared.
  - Go to REQ.
- REQ:
  - mem_req=1.
  - mem_addr = miss_pc with bits [2+log2(BEATS):0] zeroed.
  - mem_req and mem_addr are held stable until mem_ack=1; mem_req drops the cycle after ack is seen.
  - On ack go to RECV with count=0.
- RECV:
  - Each cycle with mem_valid=1 registers one beat. In the next cycle: fill=1, fill_idx=base_idx+count, stream=mem_data.
  - Then count increments.
  - Gaps (mem_valid=0) are allowed; fill=0 during gaps.
  - After beat BEATS-1 is accepted, go to COMMIT.
- COMMIT, one cycle:
  - tag_write=1, tag_idx=miss_pc[7:3], tag_value=miss_pc[31:8].
  - The last fill strobe coincides with this cycle.
- SETTLE, one cycle, lets the tag lookup re-evaluate:
  - miss is ignored; stall=1.
  - Go to IDLE.
- If miss is still 1 on return to IDLE, a new refill starts. There is no loop guard; the tag store must make a committed line hit.
- mem_valid outside RECV is ignored and produces no fill.
- mem_ack outside REQ is ignored.
- Index arithmetic: fill_idx addition is modulo 2^IDX_W; a burst never crosses the aligned BEATS-line group.
- fill, tag_write and mem_req are never asserted in IDLE.
- Latency: best-case miss-to-stall-release is 2+BEATS+2 cycles: REQ with immediate ack, BEATS beats, COMMIT, SETTLE.

Decomposition:
- Shared package holds:
  - state enum (IDLE/REQ/RECV/COMMIT/SETTLE)
  - LINE_BYTES=8
  - the index/tag bit-slice constants IDX_LSB=3, IDX_MSB=7, TAG_LSB=8
- Fetch and the refill engine both use these constants.
- One sub-module is natural: refill_beat_counter.
  - Inputs: load, inc, base.
  - Outputs: fill_idx, last.
- The FSM stays in icache_refill.

Test Plan:
- Reset mid-RECV after beat 1 of 4 -> next cycle state IDLE; stall=miss; fill, tag_write and mem_req all 0; later stray mem_valid produces no fill.
- miss=1, pc=0x0000_0134, immediate ack, 4 consecutive beats D0..D3:
  - mem_addr=0x0000_0120
  - fill_idx=4,5,6,7 with stream=D0..D3
  - tag_write with tag_idx=6, tag_value=0x000001
  - stall low 8 cycles after miss
- mem_ack delayed 5 cycles -> mem_req and mem_addr stable for all 6 cycles; no fill before ack.
- Beats with gaps (valid pattern 1,0,0,1,1,0,1) -> exactly 4 fill pulses, fill_idx consecutive, fill=0 in gap cycles.
- miss held 1 through SETTLE and into IDLE -> second REQ issued; no spurious second tag_write before its 4 beats arrive.
- BEATS=1, pc=0xFFFF_FFF8 -> mem_addr=0xFFFF_FFF8, single fill at fill_idx=31, tag_value=0xFFFFFF, no index wrap beyond 31.
